label_color_stats: RTL and testbench
====================================

# label_color_stats

Consumer side of the per-pixel label stream produced by the HSV labeling stage. Decodes each 3-bit class label (0 ROAD, 1 WALK_ROAD, 2 BACKGROUND, 3 CAR, 4 HUMAN) into a 12-bit RGB444 overlay pixel for the VGA path. In parallel, it accumulates per-frame CAR and HUMAN pixel counts. At frame end it publishes those counts and threshold-based detect flags for the road-control logic.

## Interface
- CNT_W, 17, width of pixel counters (covers 320x240 = 76800)
- CAR_TH, 2000, car_detect asserted when frame CAR count >= CAR_TH
- HUMAN_TH, 500, human_detect asserted when frame HUMAN count >= HUMAN_TH
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- label_valid  in  1  label_data/rgb_in carry a valid pixel this cycle
- label_data  in  3  class label of current pixel
- rgb_in  in  12  original camera pixel, RGB444, aligned with label_data
- frame_start  in  1  one-cycle pulse, frame begins (may coincide with first pixel)
- frame_end  in  1  one-cycle pulse, frame ends (may coincide with last pixel)
- overlay_en  in  1  1: label colors; 0: rgb_in passthrough
- rgb_valid_out  out  1  label_valid delayed 2 cycles
- rgb_out  out  12  decoded/overlaid pixel
- car_cnt  out  CNT_W  CAR pixel count of last completed frame
- human_cnt  out  CNT_W  HUMAN pixel count of last completed frame
- stats_valid  out  1  one-cycle pulse when car_cnt/human_cnt/flags update
- car_detect  out  1  car_cnt >= CAR_TH for last completed frame
- human_detect  out  1  human_cnt >= HUMAN_TH for last completed frame

## Operation
- Color map (overlay_en=1): ROAD -> 0x444, WALK_ROAD -> 0xFFF, BACKGROUND -> rgb_in, CAR -> 0xF00, HUMAN -> 0x0F0, labels 5-7 -> 0xF0F (error marker).
- overlay_en=0: rgb_out = rgb_in; same latency as the overlay path. overlay_en is sampled in stage 1 together with the pixel.
- Pipeline: stage 1 registers label_data, rgb_in, label_valid, overlay_en. Stage 2 registers the mux result. When rgb_valid_out=0, rgb_out holds its last value.
- Coloring runs in every FSM state. Counting happens only in ACTIVE.
- FSM states:
  - IDLE: frame_start -> ACTIVE, clears both accumulators.
  - ACTIVE: label_valid with CAR/HUMAN increments the matching accumulator. frame_end -> DONE, and the outputs latch the accumulator values including any pixel presented in the frame_end cycle. frame_start with no frame_end -> stays ACTIVE, accumulators are restarted (the aborted frame publishes nothing).
  - DONE: one cycle; stats_valid=1. Next state is IDLE, or ACTIVE with cleared accumulators if frame_start is present.
- Pixel in the frame_start cycle counts toward the new frame: the accumulator loads 1 or 0 instead of clearing.
- Simultaneous frame_start and frame_end in ACTIVE: frame_end wins; frame_start is ignored.
- frame_end in IDLE or DONE: ignored.
- Accumulators saturate at 2^CNT_W-1; they never wrap.
- Detect flags are computed from the latched counts with unsigned >= compares, registered together with the counts.

## Timing
- Reset: all outputs 0, FSM IDLE, accumulators 0, pipeline valid bits 0.
- Pixel latency: label_valid/label_data at cycle N -> rgb_valid_out/rgb_out at cycle N+2; throughput 1 pixel/cycle.
- frame_end at cycle N -> car_cnt, human_cnt, car_detect, human_detect updated and stats_valid=1 at cycle N+1 only.
- Published outputs hold until the next stats_valid or reset.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); the partial frame is discarded, and stats stay 0 until a full frame_start..frame_end sequence completes.

## Test plan
- Color map: overlay_en=1, labels 0..7 with rgb_in=0xABC on consecutive cycles -> rgb_out 0x444, 0xFFF, 0xABC, 0xF00, 0x0F0, 0xF0F, 0xF0F, 0xF0F, each 2 cycles after input; overlay_en=0 -> all 0xABC.
- Frame counting: frame_start with a CAR pixel, then 2499 CAR and 499 HUMAN pixels (valid gaps interleaved), frame_end with a HUMAN pixel -> car_cnt=2500, human_cnt=500, car_detect=1, human_detect=1, stats_valid high exactly one cycle after frame_end.
- Thresholds: 1999 CAR and 0 HUMAN in a frame -> car_detect=0, human_detect=0; previous values hold until that stats_valid.
- Abort and ignore: frame_start, 100 CAR, frame_start, 10 CAR, frame_end -> car_cnt=10. Isolated frame_end in IDLE -> no stats_valid. frame_start+frame_end same cycle in ACTIVE -> frame ends, no restart.
- Saturation: CNT_W=4, 20 CAR pixels in a frame -> car_cnt=15.
- Reset mid-frame: assert reset after 50 CAR pixels -> outputs 0 at once; a subsequent frame of 7 CAR pixels -> car_cnt=7.

Source files
------------

// File: rtl/label_color_stats.sv
// ============================================================================
//  Module   : label_color_stats
//  Purpose  : Decodes class labels into RGB444 overlay pixels and publishes
//             per-frame CAR/HUMAN pixel counts with threshold detect flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module label_color_stats #(
  parameter int CNT_W    = 17,
  parameter int CAR_TH   = 2000,
  parameter int HUMAN_TH = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             label_valid,
  input  logic [2:0]       label_data,
  input  logic [11:0]      rgb_in,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             overlay_en,
  output logic             rgb_valid_out,
  output logic [11:0]      rgb_out,
  output logic [CNT_W-1:0] car_cnt,
  output logic [CNT_W-1:0] human_cnt,
  output logic             stats_valid,
  output logic             car_detect,
  output logic             human_detect
);

  localparam logic [2:0] c_lbl_road       = 3'd0;
  localparam logic [2:0] c_lbl_walk_road  = 3'd1;
  localparam logic [2:0] c_lbl_background = 3'd2;
  localparam logic [2:0] c_lbl_car        = 3'd3;
  localparam logic [2:0] c_lbl_human      = 3'd4;

  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_max      = '1;
  localparam logic [CNT_W-1:0] c_car_th   = CNT_W'(CAR_TH);
  localparam logic [CNT_W-1:0] c_human_th = CNT_W'(HUMAN_TH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic             r_s1_valid;
  logic [2:0]       r_s1_label;
  logic [11:0]      r_s1_rgb;
  logic             r_s1_ovl;
  logic             r_valid_out;
  logic [11:0]      r_rgb_out;
  logic [11:0]      w_color;

  logic [CNT_W-1:0] r_car_acc, r_human_acc;
  logic [CNT_W-1:0] w_car_acc_next, w_human_acc_next;
  logic [CNT_W-1:0] w_car_inc, w_human_inc;
  logic [CNT_W-1:0] w_car_step, w_human_step;
  logic [CNT_W-1:0] w_car_load, w_human_load;
  logic             w_car_px, w_human_px;
  logic             w_publish;

  logic [CNT_W-1:0] r_car_cnt, r_human_cnt;
  logic             r_car_det, r_human_det;

  // ---------------------------------------------------------------- pixel path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_label  <= 3'd0;
      r_s1_rgb    <= 12'h000;
      r_s1_ovl    <= 1'b0;
      r_valid_out <= 1'b0;
      r_rgb_out   <= 12'h000;
    end else begin
      r_s1_valid  <= label_valid;
      r_s1_label  <= label_data;
      r_s1_rgb    <= rgb_in;
      r_s1_ovl    <= overlay_en;
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_rgb_out <= w_color;
      end
    end
  end

  always_comb begin
    w_color = r_s1_rgb;
    if (r_s1_ovl) begin
      case (r_s1_label)
        c_lbl_road:       w_color = 12'h444;
        c_lbl_walk_road:  w_color = 12'hFFF;
        c_lbl_background: w_color = r_s1_rgb;
        c_lbl_car:        w_color = 12'hF00;
        c_lbl_human:      w_color = 12'h0F0;
        default:          w_color = 12'hF0F;
      endcase
    end
  end

  // ---------------------------------------------------------------- statistics
  assign w_car_px   = label_valid && (label_data == c_lbl_car);
  assign w_human_px = label_valid && (label_data == c_lbl_human);

  // Saturating increments; a load value is used when a frame (re)starts so the
  // pixel sharing the frame_start cycle is not lost.
  assign w_car_inc    = (r_car_acc == c_max) ? r_car_acc : r_car_acc + c_one;
  assign w_human_inc  = (r_human_acc == c_max) ? r_human_acc : r_human_acc + c_one;
  assign w_car_step   = w_car_px ? w_car_inc : r_car_acc;
  assign w_human_step = w_human_px ? w_human_inc : r_human_acc;
  assign w_car_load   = w_car_px ? c_one : '0;
  assign w_human_load = w_human_px ? c_one : '0;

  always_comb begin
    w_state_next     = r_state;
    w_car_acc_next   = r_car_acc;
    w_human_acc_next = r_human_acc;
    w_publish        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_next = S_IDLE;
        if (frame_start) begin
          w_state_next     = S_ACTIVE;
          w_car_acc_next   = w_car_load;
          w_human_acc_next = w_human_load;
        end
      end
      S_ACTIVE: begin
        if (frame_end) begin
          w_state_next     = S_DONE;
          w_publish        = 1'b1;
          w_car_acc_next   = w_car_step;
          w_human_acc_next = w_human_step;
        end else if (frame_start) begin
          w_car_acc_next   = w_car_load;
          w_human_acc_next = w_human_load;
        end else begin
          w_car_acc_next   = w_car_step;
          w_human_acc_next = w_human_step;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_car_acc   <= '0;
      r_human_acc <= '0;
      r_car_cnt   <= '0;
      r_human_cnt <= '0;
      r_car_det   <= 1'b0;
      r_human_det <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_car_acc   <= w_car_acc_next;
      r_human_acc <= w_human_acc_next;
      if (w_publish) begin
        r_car_cnt   <= w_car_step;
        r_human_cnt <= w_human_step;
        r_car_det   <= (w_car_step >= c_car_th);
        r_human_det <= (w_human_step >= c_human_th);
      end
    end
  end

  assign rgb_valid_out = r_valid_out;
  assign rgb_out       = r_rgb_out;
  assign car_cnt       = r_car_cnt;
  assign human_cnt     = r_human_cnt;
  assign car_detect    = r_car_det;
  assign human_detect  = r_human_det;
  assign stats_valid   = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_label_color_stats.sv
// ============================================================================
//  Module   : tb_label_color_stats
//  Purpose  : Self-checking bench for label_color_stats (two parameter sets).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_label_color_stats;

  localparam int W_BIG = 17;
  localparam int W_SML = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        label_valid;
  logic [2:0]  label_data;
  logic [11:0] rgb_in;
  logic        frame_start;
  logic        frame_end;
  logic        overlay_en;

  logic             rgb_valid_out, stats_valid, car_detect, human_detect;
  logic [11:0]      rgb_out;
  logic [W_BIG-1:0] car_cnt, human_cnt;

  logic             s_rgb_valid_out, s_stats_valid, s_car_detect, s_human_detect;
  logic [11:0]      s_rgb_out;
  logic [W_SML-1:0] s_car_cnt, s_human_cnt;

  always #5 clk = ~clk;

  label_color_stats #(.CNT_W(W_BIG), .CAR_TH(2000), .HUMAN_TH(500)) dut (
    .clk(clk), .reset(reset), .label_valid(label_valid), .label_data(label_data),
    .rgb_in(rgb_in), .frame_start(frame_start), .frame_end(frame_end),
    .overlay_en(overlay_en), .rgb_valid_out(rgb_valid_out), .rgb_out(rgb_out),
    .car_cnt(car_cnt), .human_cnt(human_cnt), .stats_valid(stats_valid),
    .car_detect(car_detect), .human_detect(human_detect)
  );

  label_color_stats #(.CNT_W(W_SML), .CAR_TH(10), .HUMAN_TH(5)) dut_s (
    .clk(clk), .reset(reset), .label_valid(label_valid), .label_data(label_data),
    .rgb_in(rgb_in), .frame_start(frame_start), .frame_end(frame_end),
    .overlay_en(overlay_en), .rgb_valid_out(s_rgb_valid_out), .rgb_out(s_rgb_out),
    .car_cnt(s_car_cnt), .human_cnt(s_human_cnt), .stats_valid(s_stats_valid),
    .car_detect(s_car_detect), .human_detect(s_human_detect)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: raw (unsaturated) counts; saturation applied per instance.
  bit          m_active = 1'b0;
  int          m_car = 0, m_hum = 0;
  int          p_car = 0, p_hum = 0;
  bit          exp_sv = 1'b0;
  bit          prev_v = 1'b0;
  logic [11:0] prev_rgb = 12'h000;
  logic [11:0] last_rgb = 12'h000;

  typedef struct {
    logic [2:0]  l;
    bit          ov;
    logic [11:0] rgb;
    logic [11:0] exp;
  } cvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] color(input logic [2:0] l, input bit ov, input logic [11:0] rgb);
    if (!ov) return rgb;
    case (l)
      3'd0:    return 12'h444;
      3'd1:    return 12'hFFF;
      3'd2:    return rgb;
      3'd3:    return 12'hF00;
      3'd4:    return 12'h0F0;
      default: return 12'hF0F;
    endcase
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_stats();
    check("stats_valid", 32'(stats_valid), 32'(exp_sv));
    check("car_cnt", 32'(car_cnt), sat(p_car, W_BIG));
    check("human_cnt", 32'(human_cnt), sat(p_hum, W_BIG));
    check("car_detect", 32'(car_detect), 32'(sat(p_car, W_BIG) >= 2000));
    check("human_detect", 32'(human_detect), 32'(sat(p_hum, W_BIG) >= 500));
    check("s_stats_valid", 32'(s_stats_valid), 32'(exp_sv));
    check("s_car_cnt", 32'(s_car_cnt), sat(p_car, W_SML));
    check("s_human_cnt", 32'(s_human_cnt), sat(p_hum, W_SML));
    check("s_car_detect", 32'(s_car_detect), 32'(sat(p_car, W_SML) >= 10));
    check("s_human_detect", 32'(s_human_detect), 32'(sat(p_hum, W_SML) >= 5));
  endtask

  // Drive one cycle, advance the model, then check just after the edge.
  task automatic step(input bit v, input logic [2:0] l, input logic [11:0] rgb,
                      input bit fs, input bit fe, input bit ov);
    int          cpx, hpx;
    logic [11:0] e_rgb;
    label_valid = v; label_data = l; rgb_in = rgb;
    frame_start = fs; frame_end = fe; overlay_en = ov;
    cpx = (v && l == 3'd3) ? 1 : 0;
    hpx = (v && l == 3'd4) ? 1 : 0;
    exp_sv = 1'b0;
    if (m_active) begin
      if (fe) begin
        p_car = m_car + cpx; p_hum = m_hum + hpx;
        exp_sv = 1'b1; m_active = 1'b0;
      end else if (fs) begin
        m_car = cpx; m_hum = hpx;
      end else begin
        m_car += cpx; m_hum += hpx;
      end
    end else if (fs) begin
      m_active = 1'b1; m_car = cpx; m_hum = hpx;
    end
    @(posedge clk); #1;
    e_rgb = prev_v ? prev_rgb : last_rgb;
    check("rgb_valid_out", 32'(rgb_valid_out), 32'(prev_v));
    check("rgb_out", 32'(rgb_out), 32'(e_rgb));
    check("s_rgb_out", 32'(s_rgb_out), 32'(e_rgb));
    last_rgb = e_rgb;
    prev_v   = v;
    prev_rgb = color(l, ov, rgb);
    check_stats();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 12'h000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pix(input int n, input logic [2:0] l);
    for (int i = 0; i < n; i++) step(1'b1, l, 12'h123, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    label_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_rgb_valid", 32'(rgb_valid_out), 0);
    check("rst_rgb_out", 32'(rgb_out), 0);
    check("rst_car_cnt", 32'(car_cnt), 0);
    check("rst_human_cnt", 32'(human_cnt), 0);
    check("rst_stats_valid", 32'(stats_valid), 0);
    check("rst_detect", 32'({car_detect, human_detect}), 0);
    check("rst_s_car_cnt", 32'(s_car_cnt), 0);
    m_active = 1'b0; m_car = 0; m_hum = 0; p_car = 0; p_hum = 0;
    exp_sv = 1'b0; prev_v = 1'b0; last_rgb = 12'h000;
    #2;
    reset = 1'b0;
  endtask

  cvec_t tbl[16];
  logic [11:0] ovl_exp [8] = '{12'h444, 12'hFFF, 12'hABC, 12'hF00,
                               12'h0F0, 12'hF0F, 12'hF0F, 12'hF0F};

  initial begin
    int p, c;
    bit v, fs, fe, ov;
    logic [2:0] l;

    reset = 1'b1; label_valid = 1'b0; label_data = 3'd0; rgb_in = 12'h000;
    frame_start = 1'b0; frame_end = 1'b0; overlay_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_rgb_valid", 32'(rgb_valid_out), 0);
    check("init_rgb_out", 32'(rgb_out), 0);
    check("init_car_cnt", 32'(car_cnt), 0);
    check("init_stats_valid", 32'(stats_valid), 0);
    reset = 1'b0;

    // Color map: overlay on for labels 0..7, then passthrough
    for (int i = 0; i < 16; i++) begin
      tbl[i].l   = 3'(i % 8);
      tbl[i].ov  = (i < 8);
      tbl[i].rgb = 12'hABC;
      tbl[i].exp = (i < 8) ? ovl_exp[i] : 12'hABC;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].l, tbl[i].rgb, 1'b0, 1'b0, tbl[i].ov);
      if (i > 0) check("cmap", 32'(rgb_out), 32'(tbl[i-1].exp));
    end
    idle(1);
    check("cmap_last", 32'(rgb_out), 32'(tbl[15].exp));
    idle(2);
    check("cmap_hold", 32'(rgb_out), 32'h0ABC);

    // Frame counting with gaps, pixels in start and end cycles
    step(1'b1, 3'd3, 12'h111, 1'b1, 1'b0, 1'b1);
    p = 0; c = 0;
    while (p < 2998) begin
      if (c % 5 == 4) step(1'b0, 3'd3, 12'h111, 1'b0, 1'b0, 1'b1);
      else begin
        step(1'b1, (p < 2499) ? 3'd3 : 3'd4, 12'h111, 1'b0, 1'b0, 1'b1);
        p++;
      end
      c++;
    end
    step(1'b1, 3'd4, 12'h111, 1'b0, 1'b1, 1'b1);
    check("fc_sv", 32'(stats_valid), 1);
    check("fc_car", 32'(car_cnt), 2500);
    check("fc_hum", 32'(human_cnt), 500);
    check("fc_det", 32'({car_detect, human_detect}), 3);
    idle(1);
    check("fc_sv_pulse", 32'(stats_valid), 0);

    // Just below threshold; previous values hold until publish
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(1999, 3'd3);
    check("th_hold", 32'(car_cnt), 2500);
    step(1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    check("th_car", 32'(car_cnt), 1999);
    check("th_hum", 32'(human_cnt), 0);
    check("th_det", 32'({car_detect, human_detect}), 0);

    // Abort restart, isolated frame_end, start+end collision
    idle(1);
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(100, 3'd3);
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(10, 3'd3);
    step(1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    check("abort_car", 32'(car_cnt), 10);
    idle(2);
    step(1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    check("idle_fe_sv", 32'(stats_valid), 0);
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(3, 3'd3);
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b1, 1'b1);
    check("coll_sv", 32'(stats_valid), 1);
    check("coll_car", 32'(car_cnt), 3);
    idle(1);
    step(1'b1, 3'd3, 12'h000, 1'b0, 1'b1, 1'b1);
    check("coll_norestart", 32'(stats_valid), 0);

    // Saturation on the narrow instance
    idle(1);
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(20, 3'd3);
    step(1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    check("sat_s_car", 32'(s_car_cnt), 15);
    check("sat_s_det", 32'(s_car_detect), 1);
    check("sat_big_car", 32'(car_cnt), 20);

    // Reset mid-frame, then a fresh frame
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(50, 3'd3);
    do_reset();
    idle(1);
    step(1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    check("rst_fe_ignored", 32'(stats_valid), 0);
    step(1'b0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b1);
    pix(7, 3'd3);
    step(1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 1'b1);
    check("rst_new_car", 32'(car_cnt), 7);

    // Randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      v  = ($urandom_range(0, 9) < 7);
      c  = $urandom_range(0, 3);
      l  = (c == 0) ? 3'd3 : (c == 1) ? 3'd4 : 3'($urandom_range(0, 7));
      fs = ($urandom_range(0, 199) == 0);
      fe = ($urandom_range(0, 149) == 0);
      ov = ($urandom_range(0, 7) != 0);
      step(v, l, 12'($urandom), fs, fe, ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
